// File: rtl/spike_mac_pkg.sv
// Shared defaults, column-sum width helper and frame-control state type for the
// sequential spike MAC accumulator.
package spike_mac_pkg;

  localparam int N_IN_DEF      = 8;
  localparam int N_OUT_DEF     = 8;
  localparam int W_WIDTH_DEF   = 8;
  // Matches the DPE OUT_WIDTH so frame results drop straight into the activation stage.
  localparam int ACC_WIDTH_DEF = 16;
  localparam int STEP_W_DEF    = 8;

  // Width that holds the sum of n_in unsigned w_width-bit weights without overflow.
  function automatic int csum_w(input int w_width, input int n_in);
    return w_width + $clog2(n_in + 1);
  endfunction

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/spike_colsum.sv
// Combinational masked column-sum array: csum[k] = sum over j of spikes[j] ? W[j][k] : 0.
module spike_colsum
  import spike_mac_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int N_OUT   = N_OUT_DEF,
  parameter int W_WIDTH = W_WIDTH_DEF,
  parameter int CSUM_W  = csum_w(W_WIDTH, N_IN)
) (
  input  logic [N_IN*N_OUT*W_WIDTH-1:0] weights,
  input  logic [N_IN-1:0]               spikes,
  output logic [N_OUT*CSUM_W-1:0]       csums
);

  always_comb begin : colsum_array
    logic [CSUM_W-1:0] sum;
    sum   = '0;
    csums = '0;
    for (int k = 0; k < N_OUT; k++) begin
      sum = '0;
      for (int j = 0; j < N_IN; j++) begin
        if (spikes[j]) begin
          sum = sum + CSUM_W'(weights[(j*N_OUT+k)*W_WIDTH +: W_WIDTH]);
        end
      end
      csums[k*CSUM_W +: CSUM_W] = sum;
    end
  end

endmodule

// File: rtl/spike_mac_accum.sv
// Sequential spike MAC: registered weight matrix, one-deep column-sum stage and
// per-column frame accumulators. Define SPIKE_MAC_ACCUM_SAT_EN for clamping accumulators.
module spike_mac_accum
  import spike_mac_pkg::*;
#(
  parameter int N_IN      = N_IN_DEF,
  parameter int N_OUT     = N_OUT_DEF,
  parameter int W_WIDTH   = W_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int STEP_W    = STEP_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         w_we,
  input  logic [$clog2(N_IN)-1:0]      w_row,
  input  logic [N_OUT*W_WIDTH-1:0]     w_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_IN-1:0]              in_spikes,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_OUT*ACC_WIDTH-1:0]   out_sums,
  output logic [STEP_W-1:0]            out_steps,
  output logic [N_OUT-1:0]             out_sat
);

  localparam int CSUM_W = csum_w(W_WIDTH, N_IN);
  localparam int ROW_W  = $clog2(N_IN);
  localparam logic [ROW_W:0] N_IN_L = (ROW_W+1)'(N_IN);

  state_e state_q, state_d;

  logic [N_IN-1:0][N_OUT*W_WIDTH-1:0] w_q, w_d;
  logic [N_OUT-1:0][CSUM_W-1:0]       csum_p0, csum_p1_q, csum_p1_d;
  logic                               vld_p1_q, vld_p1_d;
  logic                               last_p1_q, last_p1_d;
  logic [N_OUT-1:0][ACC_WIDTH-1:0]    acc_q, acc_d, acc_nxt;
  logic [N_OUT-1:0][ACC_WIDTH-1:0]    out_sums_q, out_sums_d;
  logic [STEP_W-1:0]                  steps_q, steps_d, steps_nxt;
  logic [STEP_W-1:0]                  out_steps_q, out_steps_d;
  logic                               accept;
`ifdef SPIKE_MAC_ACCUM_SAT_EN
  logic [N_OUT-1:0]                   sat_q, sat_d, sat_nxt;
  logic [N_OUT-1:0]                   out_sat_q, out_sat_d;
`endif

  function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [CSUM_W-1:0]    c);
`ifdef SPIKE_MAC_ACCUM_SAT_EN
    logic [ACC_WIDTH:0] full;
    full = {1'b0, a} + (ACC_WIDTH+1)'(c);
    return full[ACC_WIDTH] ? '1 : full[ACC_WIDTH-1:0];
`else
    return a + ACC_WIDTH'(c);
`endif
  endfunction

`ifdef SPIKE_MAC_ACCUM_SAT_EN
  function automatic logic acc_ovf(input logic [ACC_WIDTH-1:0] a,
                                   input logic [CSUM_W-1:0]    c);
    logic [ACC_WIDTH:0] full;
    full = {1'b0, a} + (ACC_WIDTH+1)'(c);
    return full[ACC_WIDTH];
  endfunction
`endif

  function automatic logic [STEP_W-1:0] step_inc(input logic [STEP_W-1:0] s);
    return (&s) ? s : s + 1'b1;
  endfunction

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;

  spike_colsum #(
    .N_IN    (N_IN),
    .N_OUT   (N_OUT),
    .W_WIDTH (W_WIDTH),
    .CSUM_W  (CSUM_W)
  ) u_colsum (
    .weights (w_q),
    .spikes  (in_spikes),
    .csums   (csum_p0)
  );

  // ---- S0 -> S1: weight update and column-sum capture (old weights on a same-cycle write)
  always_comb begin
    w_d = w_q;
    if (w_we && ({1'b0, w_row} < N_IN_L)) begin
      w_d[w_row] = w_data;
    end
    csum_p1_d = csum_p1_q;
    vld_p1_d  = accept;
    last_p1_d = 1'b0;
    if (accept) begin
      csum_p1_d = csum_p0;
      last_p1_d = in_last;
    end
  end

  // ---- S1 -> S2: integration into accumulators and frame control
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      acc_nxt[k] = acc_add(acc_q[k], csum_p1_q[k]);
    end
    steps_nxt   = step_inc(steps_q);
    state_d     = state_q;
    acc_d       = acc_q;
    steps_d     = steps_q;
    out_sums_d  = out_sums_q;
    out_steps_d = out_steps_q;
`ifdef SPIKE_MAC_ACCUM_SAT_EN
    for (int k = 0; k < N_OUT; k++) begin
      sat_nxt[k] = sat_q[k] | acc_ovf(acc_q[k], csum_p1_q[k]);
    end
    sat_d     = sat_q;
    out_sat_d = out_sat_q;
`endif
    if (vld_p1_q) begin
      acc_d   = acc_nxt;
      steps_d = steps_nxt;
`ifdef SPIKE_MAC_ACCUM_SAT_EN
      sat_d   = sat_nxt;
`endif
    end
    case (state_q)
      ACCUM: begin
        if (accept && in_last) state_d = FLUSH;
      end
      FLUSH: begin
        // Publish the post-integration totals and start the next frame from zero.
        if (vld_p1_q && last_p1_q) begin
          out_sums_d  = acc_nxt;
          out_steps_d = steps_nxt;
          acc_d       = '0;
          steps_d     = '0;
`ifdef SPIKE_MAC_ACCUM_SAT_EN
          out_sat_d   = sat_nxt;
          sat_d       = '0;
`endif
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      w_q         <= '0;
      csum_p1_q   <= '0;
      vld_p1_q    <= 1'b0;
      last_p1_q   <= 1'b0;
      acc_q       <= '0;
      steps_q     <= '0;
      out_sums_q  <= '0;
      out_steps_q <= '0;
`ifdef SPIKE_MAC_ACCUM_SAT_EN
      sat_q       <= '0;
      out_sat_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      csum_p1_q   <= csum_p1_d;
      vld_p1_q    <= vld_p1_d;
      last_p1_q   <= last_p1_d;
      acc_q       <= acc_d;
      steps_q     <= steps_d;
      out_sums_q  <= out_sums_d;
      out_steps_q <= out_steps_d;
`ifdef SPIKE_MAC_ACCUM_SAT_EN
      sat_q       <= sat_d;
      out_sat_q   <= out_sat_d;
`endif
    end
  end

  assign out_sums  = out_sums_q;
  assign out_steps = out_steps_q;
`ifdef SPIKE_MAC_ACCUM_SAT_EN
  assign out_sat   = out_sat_q;
`else
  assign out_sat   = '0;
`endif

endmodule
